// File: rtl/alu_mula_unit.sv
// rtl/alu_mula_unit.sv - execute-stage ALU with multi-cycle signed multiply-accumulate into {Hi,Lo}
// Combinational ops resolve in the issuing cycle; MULA runs a WIDTH-step shift-add then accumulates.

module alu_mula_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [3:0]       alu_ctrl_i,
   input  logic [WIDTH-1:0] bus_a_i,
   input  logic [WIDTH-1:0] bus_b_i,
   input  logic [4:0]       shamt_i,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             overflow_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam logic [3:0] OP_AND  = 4'h0;
   localparam logic [3:0] OP_OR   = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SLL  = 4'h3;
   localparam logic [3:0] OP_SRL  = 4'h4;
   localparam logic [3:0] OP_MULA = 4'h5;
   localparam logic [3:0] OP_SUB  = 4'h6;
   localparam logic [3:0] OP_SLT  = 4'h7;
   localparam logic [3:0] OP_ADDU = 4'h8;
   localparam logic [3:0] OP_SUBU = 4'h9;
   localparam logic [3:0] OP_XOR  = 4'hA;
   localparam logic [3:0] OP_SLTU = 4'hB;
   localparam logic [3:0] OP_NOR  = 4'hC;
   localparam logic [3:0] OP_SRA  = 4'hD;
   localparam logic [3:0] OP_LUI  = 4'hE;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_ACC  = 2'd2;

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [1:0]         state_q,  state_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic [2*WIDTH-1:0] mcand_q,  mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic               sign_q,   sign_d;
   logic [2*WIDTH-1:0] prod_q,   prod_d;
   logic [2*WIDTH-1:0] acc_q,    acc_d;

   logic [WIDTH-1:0]   a_abs;
   logic [WIDTH-1:0]   b_abs;
   logic               busy;

   // Magnitudes are taken as unsigned, so the most negative value maps onto itself correctly.
   assign a_abs = bus_a_i[WIDTH-1] ? -bus_a_i : bus_a_i;
   assign b_abs = bus_b_i[WIDTH-1] ? -bus_b_i : bus_b_i;
   assign busy  = (state_q != S_IDLE);

   // MULA sequencer: latch magnitudes, shift-add one multiplier bit per cycle, then signed accumulate.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      sign_d   = sign_q;
      prod_d   = prod_q;
      acc_d    = acc_q;
      case (state_q)
         S_IDLE: begin
            if (start_i && (alu_ctrl_i == OP_MULA)) begin
               mcand_d  = {{WIDTH{1'b0}}, a_abs};
               mplier_d = b_abs;
               sign_d   = bus_a_i[WIDTH-1] ^ bus_b_i[WIDTH-1];
               prod_d   = '0;
               cnt_d    = '0;
               state_d  = S_MUL;
            end
         end
         S_MUL: begin
            prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (cnt_q == CNT_LAST) begin
               state_d = S_ACC;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_ACC: begin
            acc_d   = acc_q + (sign_q ? -prod_q : prod_q);
            cnt_d   = '0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any MULA in flight and clears the accumulator.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         sign_q   <= 1'b0;
         prod_q   <= '0;
         acc_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         sign_q   <= sign_d;
         prod_q   <= prod_d;
         acc_q    <= acc_d;
      end
   end

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] sra_res;
   logic             add_ovf;
   logic             sub_ovf;

   assign sum     = bus_a_i + bus_b_i;
   assign diff    = bus_a_i - bus_b_i;
   assign sra_res = $signed(bus_b_i) >>> shamt_i;
   assign add_ovf = (bus_a_i[WIDTH-1] == bus_b_i[WIDTH-1]) && (sum[WIDTH-1]  != bus_a_i[WIDTH-1]);
   assign sub_ovf = (bus_a_i[WIDTH-1] != bus_b_i[WIDTH-1]) && (diff[WIDTH-1] != bus_a_i[WIDTH-1]);

   // Result mux: while a MULA is running, or when MULA is selected, expose the pre-update Lo.
   always_comb begin
      result_o   = '0;
      overflow_o = 1'b0;
      if (busy) begin
         result_o = acc_q[WIDTH-1:0];
      end else begin
         case (alu_ctrl_i)
            OP_AND:  result_o = bus_a_i & bus_b_i;
            OP_OR:   result_o = bus_a_i | bus_b_i;
            OP_ADD: begin
               result_o   = sum;
               overflow_o = add_ovf;
            end
            OP_SLL:  result_o = bus_b_i << shamt_i;
            OP_SRL:  result_o = bus_b_i >> shamt_i;
            OP_MULA: result_o = acc_q[WIDTH-1:0];
            OP_SUB: begin
               result_o   = diff;
               overflow_o = sub_ovf;
            end
            OP_SLT:  result_o = {{(WIDTH-1){1'b0}}, ($signed(bus_a_i) < $signed(bus_b_i))};
            OP_ADDU: result_o = sum;
            OP_SUBU: result_o = diff;
            OP_XOR:  result_o = bus_a_i ^ bus_b_i;
            OP_SLTU: result_o = {{(WIDTH-1){1'b0}}, (bus_a_i < bus_b_i)};
            OP_NOR:  result_o = ~(bus_a_i | bus_b_i);
            OP_SRA:  result_o = sra_res;
            OP_LUI:  result_o = {bus_b_i[15:0], {(WIDTH-16){1'b0}}};
            default: result_o = '0;
         endcase
      end
   end

   assign zero_o = (result_o == '0);
   assign busy_o = busy;
   assign done_o = (state_q == S_ACC);
   assign hi_o   = acc_q[2*WIDTH-1:WIDTH];
   assign lo_o   = acc_q[WIDTH-1:0];

endmodule

// File: tb/tb_alu_mula_unit.sv
// tb/tb_alu_mula_unit.sv - self-checking bench for alu_mula_unit with a reference model and directed vectors

module tb_alu_mula_unit;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [3:0]    ctrl;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic [4:0]    sh;
   logic [W-1:0]  result;
   logic          zero;
   logic          ovf;
   logic          busy;
   logic          done;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   int n_cmp = 0;
   int n_bad = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   alu_mula_unit #(.WIDTH(W)) dut (
      .clk_i      (clk),
      .reset_i    (reset),
      .start_i    (start),
      .alu_ctrl_i (ctrl),
      .bus_a_i    (a),
      .bus_b_i    (b),
      .shamt_i    (sh),
      .result_o   (result),
      .zero_o     (zero),
      .overflow_o (ovf),
      .busy_o     (busy),
      .done_o     (done),
      .hi_o       (hi),
      .lo_o       (lo)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] sprod(input logic [31:0] x, input logic [31:0] y);
      longint px;
      longint py;
      px = longint'($signed(x));
      py = longint'($signed(y));
      return px * py;
   endfunction

   // Returns {overflow, result} from plain integer arithmetic.
   function automatic logic [32:0] ref_op(input logic [3:0] c, input logic [31:0] x,
                                          input logic [31:0] y, input logic [4:0] s);
      longint sx;
      longint sy;
      longint ux;
      longint uy;
      longint t;
      logic [31:0] r;
      logic o;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = longint'({32'h0, x});
      uy = longint'({32'h0, y});
      r = 32'h0;
      o = 1'b0;
      case (c)
         4'h0: r = x & y;
         4'h1: r = x | y;
         4'h2: begin t = sx + sy; r = 32'(t); o = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
         4'h3: r = 32'(uy * (64'sd1 <<< s));
         4'h4: r = 32'(uy / (64'sd1 <<< s));
         4'h6: begin t = sx - sy; r = 32'(t); o = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
         4'h7: r = (sx < sy) ? 32'd1 : 32'd0;
         4'h8: r = 32'(ux + uy);
         4'h9: r = 32'(ux - uy);
         4'hA: r = x ^ y;
         4'hB: r = (ux < uy) ? 32'd1 : 32'd0;
         4'hC: r = ~(x | y);
         4'hD: r = 32'(sy >>> s);
         4'hE: r = 32'(uy * 64'sd65536);
         default: r = 32'h0;
      endcase
      return {o, r};
   endfunction

   // Reference model: a MULA occupies W+1 cycles, accumulating the signed product in its last cycle.
   logic [63:0] m_acc = 64'h0;
   logic [63:0] m_prod = 64'h0;
   int          m_cyc = 0;

   always @(posedge clk) begin
      if (reset) begin
         m_acc <= 64'h0;
         m_cyc <= 0;
      end else if (m_cyc == W + 1) begin
         m_acc <= m_acc + m_prod;
         m_cyc <= 0;
      end else if (m_cyc > 0) begin
         m_cyc <= m_cyc + 1;
      end else if (start && ctrl == 4'h5) begin
         m_prod <= sprod(a, b);
         m_cyc  <= 1;
      end
   end

   always @(negedge clk) begin
      logic [32:0] r;
      logic        busy_e;
      logic [31:0] res_e;
      logic        ovf_e;
      if (chk_en) begin
         busy_e = (m_cyc != 0);
         if (busy_e || ctrl == 4'h5) begin
            res_e = m_acc[31:0];
            ovf_e = 1'b0;
         end else begin
            r = ref_op(ctrl, a, b, sh);
            res_e = r[31:0];
            ovf_e = r[32];
         end
         check("busy",     64'(busy),   64'(busy_e));
         check("done",     64'(done),   64'(m_cyc == W + 1));
         check("result",   64'(result), 64'(res_e));
         check("zero",     64'(zero),   64'(res_e == 32'h0));
         check("overflow", 64'(ovf),    64'(ovf_e));
         check("hi",       64'(hi),     64'(m_acc[63:32]));
         check("lo",       64'(lo),     64'(m_acc[31:0]));
      end
   end

   typedef struct {
      logic [3:0]  c;
      logic [31:0] x;
      logic [31:0] y;
      logic [4:0]  s;
      logic [31:0] r;
      logic        o;
   } vec_t;

   vec_t vecs [17] = '{
      '{4'h2, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b1},
      '{4'h8, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0},
      '{4'h6, 32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b0},
      '{4'hD, 32'h00000000, 32'h80000000, 5'd4,  32'hF8000000, 1'b0},
      '{4'h4, 32'h00000000, 32'h80000000, 5'd4,  32'h08000000, 1'b0},
      '{4'hE, 32'h00000000, 32'h00001234, 5'd0,  32'h12340000, 1'b0},
      '{4'h7, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b0},
      '{4'hB, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b0},
      '{4'h6, 32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b1},
      '{4'h2, 32'h80000000, 32'h80000000, 5'd0,  32'h00000000, 1'b1},
      '{4'h0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0},
      '{4'h1, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hFFF0FFF0, 1'b0},
      '{4'hA, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h0FF00FF0, 1'b0},
      '{4'hC, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h000F000F, 1'b0},
      '{4'h3, 32'h00000000, 32'h00000001, 5'd31, 32'h80000000, 1'b0},
      '{4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'h00000000, 1'b0},
      '{4'h9, 32'h00000000, 32'h00000001, 5'd0,  32'hFFFFFFFF, 1'b0}
   };

   task automatic do_reset();
      @(posedge clk); #2;
      reset = 1'b1;
      @(posedge clk); #2;
      reset = 1'b0;
   endtask

   task automatic do_mula(input logic [31:0] x, input logic [31:0] y, input bit inj,
                          output int nb, output int done_at);
      @(posedge clk); #2;
      start = 1'b1;
      ctrl  = 4'h5;
      a     = x;
      b     = y;
      @(posedge clk); #2;
      start = 1'b0;
      nb = 0;
      done_at = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk); #1;
         if (busy) nb++;
         if (done) done_at = k;
         if (k == 3) begin
            a = $urandom;
            b = $urandom;
         end
         if (inj && k == 10) start = 1'b1;
         if (inj && k == 11) start = 1'b0;
         if (!busy) break;
      end
   endtask

   initial begin
      int nb;
      int dat;
      reset = 1'b1;
      start = 1'b0;
      ctrl  = 4'h0;
      a     = 32'h0;
      b     = 32'h0;
      sh    = 5'd0;
      repeat (2) @(posedge clk);
      #2;
      reset  = 1'b0;
      chk_en = 1'b1;

      @(negedge clk); #1;
      check("reset_busy", 64'(busy), 64'h0);
      check("reset_done", 64'(done), 64'h0);
      check("reset_hi",   64'(hi),   64'h0);
      check("reset_lo",   64'(lo),   64'h0);

      for (int i = 0; i < 17; i++) begin
         @(posedge clk); #2;
         ctrl = vecs[i].c;
         a    = vecs[i].x;
         b    = vecs[i].y;
         sh   = vecs[i].s;
         @(negedge clk); #1;
         check($sformatf("vec%0d_result", i), 64'(result), 64'(vecs[i].r));
         check($sformatf("vec%0d_ovf", i),    64'(ovf),    64'(vecs[i].o));
         check($sformatf("vec%0d_zero", i),   64'(zero),   64'(vecs[i].r == 32'h0));
      end

      do_mula(32'd3, 32'hFFFFFFFC, 1'b0, nb, dat);
      check("mula1_busy_cycles", 64'(nb),  64'd33);
      check("mula1_done_cycle",  64'(dat), 64'd33);
      check("mula1_acc", {hi, lo}, 64'hFFFFFFFF_FFFFFFF4);

      do_mula(32'd3, 32'hFFFFFFFC, 1'b1, nb, dat);
      check("mula2_busy_cycles", 64'(nb),  64'd33);
      check("mula2_acc", {hi, lo}, 64'hFFFFFFFF_FFFFFFE8);
      repeat (3) @(posedge clk);
      #1;
      check("mula2_no_restart", 64'(busy), 64'h0);

      do_reset();
      do_mula(32'h80000000, 32'h80000000, 1'b0, nb, dat);
      check("mula_minmin_acc", {hi, lo}, 64'h40000000_00000000);
      do_mula(32'hFFFFFFFF, 32'h00000001, 1'b0, nb, dat);
      check("mula_neg1_acc", {hi, lo}, 64'h3FFFFFFF_FFFFFFFF);

      do_mula(32'h0, 32'h0, 1'b0, nb, dat);
      check("mula_zero_done", 64'(dat), 64'd33);
      check("mula_zero_acc", {hi, lo}, 64'h3FFFFFFF_FFFFFFFF);

      @(posedge clk); #2;
      start = 1'b1;
      ctrl  = 4'h5;
      a     = 32'd5;
      b     = 32'd7;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      reset = 1'b1;
      @(posedge clk); #2;
      reset = 1'b0;
      @(negedge clk); #1;
      check("abort_busy", 64'(busy),   64'h0);
      check("abort_done", 64'(done),   64'h0);
      check("abort_acc",  {hi, lo},    64'h0);

      do_mula(32'd2, 32'd2, 1'b0, nb, dat);
      check("post_abort_lo", 64'(lo), 64'd4);
      check("post_abort_hi", 64'(hi), 64'd0);

      @(posedge clk); #2;
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
